// File: rtl/rand_vector_generator.sv
// rand_vector_generator: fills an HID_DIM-element hidden vector from a 32-bit
// Galois LFSR, one element per cycle, when the top level enters MIX1.
// GEN_NEW writes the raw LFSR bits. GEN_SIMI writes them arithmetically
// shifted down, so the new vector stays close to the previous one.
// FORWARD/BACKWARD publish an all-zero vector right away.

`ifndef HID_DIM
`define HID_DIM 4
`endif
`ifndef N_LEN
`define N_LEN 16
`endif
`ifndef STATE_LEN
`define STATE_LEN 3
`endif
`ifndef MODE_LEN
`define MODE_LEN 2
`endif
`ifndef MIX1
`define MIX1 3'd1
`endif
`ifndef MIX2
`define MIX2 3'd2
`endif
`ifndef MIX3
`define MIX3 3'd3
`endif
`ifndef FORWARD
`define FORWARD 2'd0
`endif
`ifndef BACKWARD
`define BACKWARD 2'd1
`endif
`ifndef GEN_SIMI
`define GEN_SIMI 2'd2
`endif
`ifndef GEN_NEW
`define GEN_NEW 2'd3
`endif

module rand_vector_generator #(
  parameter int          HID_DIM    = `HID_DIM,
  parameter int          N_LEN      = `N_LEN,
  parameter logic [31:0] SEED       = 32'hACE1_2468,
  parameter int          SIMI_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`STATE_LEN-1:0]     state,
  input  logic [`MODE_LEN-1:0]      mode,
  input  logic                      seed_load,
  input  logic [31:0]               seed,
  output logic                      valid,
  output logic [HID_DIM*N_LEN-1:0]  q
);

  localparam int          CNT_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, GEN, DONE} fsm_t;

  fsm_t                     fsm, fsm_nxt;
  logic [31:0]              lfsr, lfsr_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [`MODE_LEN-1:0]     mode_q;
  logic [`STATE_LEN-1:0]    state_d;
  logic                     in_mix, trigger, gen_mode, last_elem;
  logic [N_LEN-1:0]         elem, elem_w;
  logic signed [N_LEN-1:0]  elem_s, elem_sh;
  logic                     start_gen, q_clear, gen_write, seed_wr, valid_nxt;

  assign in_mix    = (state == `MIX1) || (state == `MIX2) || (state == `MIX3);
  assign trigger   = (state == `MIX1) && (state_d != `MIX1);
  assign gen_mode  = (mode == `GEN_SIMI) || (mode == `GEN_NEW);
  assign last_elem = (cnt == CNT_W'(HID_DIM - 1));

  // One Galois step; the element comes from the value the LFSR is moving to.
  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign elem     = lfsr_nxt[N_LEN-1:0];
  assign elem_s   = elem;
  // The shift sits in its own signed assignment. Inside a mixed-sign ?: it
  // would be evaluated unsigned and lose the sign fill.
  assign elem_sh  = elem_s >>> SIMI_SHIFT;
  assign elem_w   = (mode_q == `GEN_SIMI) ? elem_sh : elem;

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see the updated value.
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // Next-state logic: leaving the MIX states always wins over progress in GEN.
  // NOTE: fsm_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE: if (trigger) fsm_nxt = gen_mode ? GEN : DONE;
      GEN: begin
        if (!in_mix)        fsm_nxt = IDLE;
        else if (last_elem) fsm_nxt = DONE;
      end
      DONE: if (!in_mix) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Output decode: the strobes that steer the datapath registers.
  always_comb begin
    start_gen = (fsm == IDLE) && trigger && gen_mode;
    q_clear   = (fsm == IDLE) && trigger && !gen_mode;
    gen_write = (fsm == GEN) && in_mix;
    seed_wr   = (fsm == IDLE) && seed_load;
    valid_nxt = (fsm_nxt == DONE);
  end

  // Datapath: LFSR, element counter, sampled mode, state history, q and valid.
  // NOTE: q is a plain register bank that must read as zero after reset, so
  // it is reset along with the control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= SEED;
      cnt     <= '0;
      mode_q  <= `FORWARD;
      state_d <= '0;
      valid   <= 1'b0;
      q       <= '0;
    end else begin
      state_d <= state;
      valid   <= valid_nxt;

      // A seed load and a trigger in the same IDLE cycle both take effect,
      // so the first GEN step advances from the new seed.
      if (seed_wr)         lfsr <= (seed == 32'd0) ? 32'd1 : seed;
      else if (fsm == GEN) lfsr <= lfsr_nxt;

      if (start_gen) begin
        cnt    <= '0;
        mode_q <= mode;
      end else if (gen_write) begin
        cnt <= cnt + 1'b1;
      end

      if (q_clear)        q <= '0;
      else if (gen_write) q[cnt*N_LEN +: N_LEN] <= elem_w;
    end
  end

endmodule
